// File: rtl/io_write_arbiter_pkg.sv
// Shared Octavo I/O helpers: port index sizing and packed write-bus slicing.
package octavo_io_pkg;

  // Width of an index that can address port_count ports (at least 1 bit).
  function automatic int port_index_width(input int port_count);
    return (port_count <= 1) ? 1 : $clog2(port_count);
  endfunction

  // LSB of port's word inside the packed io_write_data bus.
  function automatic int word_lsb(input int port, input int word_width);
    return port * word_width;
  endfunction

endpackage

// File: rtl/io_write_arbiter_if.sv
// Processor write ports plus the merged downstream valid/ready stream.
interface io_write_arbiter_if
  import octavo_io_pkg::*;
#(
  parameter int WORD_WIDTH       = 36,
  parameter int PORT_COUNT       = 4,
  parameter int PORT_COUNT_WIDTH = port_index_width(PORT_COUNT)
);
  logic [PORT_COUNT-1:0]            io_wren;
  logic [PORT_COUNT*WORD_WIDTH-1:0] io_write_data;
  logic [PORT_COUNT-1:0]            io_write_EF;
  logic                             out_valid;
  logic                             out_ready;
  logic [WORD_WIDTH-1:0]            out_data;
  logic [PORT_COUNT_WIDTH-1:0]      out_port;
  logic [PORT_COUNT-1:0]            overflow;
  logic                             overflow_clear;

  // Arbiter side.
  modport slave (
    input  io_wren, io_write_data, out_ready, overflow_clear,
    output io_write_EF, out_valid, out_data, out_port, overflow
  );

  // Processor / consumer side.
  modport master (
    output io_wren, io_write_data, out_ready, overflow_clear,
    input  io_write_EF, out_valid, out_data, out_port, overflow
  );
endinterface

// File: rtl/io_write_arbiter_rr.sv
// Combinational round-robin picker: first request after last_grant, wrapping.
module rr_priority_select
  import octavo_io_pkg::*;
#(
  parameter int PORT_COUNT       = 4,
  parameter int PORT_COUNT_WIDTH = port_index_width(PORT_COUNT)
) (
  input  logic [PORT_COUNT-1:0]       req_i,
  input  logic [PORT_COUNT_WIDTH-1:0] last_grant_i,
  output logic [PORT_COUNT_WIDTH-1:0] grant_o,
  output logic                        any_grant_o
);

  // Walk from last_grant+1 for PORT_COUNT positions; the first hit wins.
  always_comb begin
    int                        idx;
    logic [PORT_COUNT_WIDTH-1:0] idx_w;
    grant_o     = '0;
    any_grant_o = 1'b0;
    for (int k = 1; k <= PORT_COUNT; k++) begin
      idx = int'(last_grant_i) + k;
      if (idx >= PORT_COUNT) idx = idx - PORT_COUNT;
      idx_w = PORT_COUNT_WIDTH'(idx);
      if (!any_grant_o && req_i[idx_w]) begin
        any_grant_o = 1'b1;
        grant_o     = idx_w;
      end
    end
  end

endmodule

// File: rtl/io_write_arbiter.sv
// Merges per-port one-word write slots into one registered, port-tagged stream.
module io_write_arbiter
  import octavo_io_pkg::*;
#(
  parameter int WORD_WIDTH       = 36,
  parameter int PORT_COUNT       = 4,
  parameter int PORT_COUNT_WIDTH = port_index_width(PORT_COUNT)
) (
  input logic              clock,
  input logic              reset_n,
  io_write_arbiter_if.slave bus
);

  logic [PORT_COUNT-1:0]       slot_full_q, slot_full_d;
  logic [WORD_WIDTH-1:0]       slot_data_q [PORT_COUNT];
  logic [WORD_WIDTH-1:0]       slot_data_d [PORT_COUNT];
  logic [PORT_COUNT-1:0]       overflow_q, overflow_d;
  logic                        out_valid_q, out_valid_d;
  logic [WORD_WIDTH-1:0]       out_data_q, out_data_d;
  logic [PORT_COUNT_WIDTH-1:0] out_port_q, out_port_d;
  logic [PORT_COUNT_WIDTH-1:0] last_grant_q, last_grant_d;

  logic                        out_free;
  logic                        any_req;
  logic                        grant_en;
  logic [PORT_COUNT_WIDTH-1:0] grant_idx;

  rr_priority_select #(
    .PORT_COUNT      (PORT_COUNT),
    .PORT_COUNT_WIDTH(PORT_COUNT_WIDTH)
  ) u_rr (
    .req_i       (slot_full_q),
    .last_grant_i(last_grant_q),
    .grant_o     (grant_idx),
    .any_grant_o (any_req)
  );

  // The output register can take a word when empty or emptying this cycle.
  assign out_free = !out_valid_q || bus.out_ready;
  assign grant_en = out_free && any_req;

  // A write into a slot that is draining this cycle is accepted (write-while-drain);
  // a write into a full, non-draining slot is dropped and flagged instead.
  for (genvar gi = 0; gi < PORT_COUNT; gi++) begin : g_slot
    logic drain;
    logic accept;
    assign drain  = grant_en && (grant_idx == PORT_COUNT_WIDTH'(gi));
    assign accept = bus.io_wren[gi] && (!slot_full_q[gi] || drain);
    assign slot_full_d[gi] = bus.io_wren[gi] | (slot_full_q[gi] & ~drain);
    assign slot_data_d[gi] = accept
                           ? bus.io_write_data[word_lsb(gi, WORD_WIDTH) +: WORD_WIDTH]
                           : slot_data_q[gi];
    // A fresh overflow outranks a simultaneous clear.
    assign overflow_d[gi]  = (bus.io_wren[gi] & slot_full_q[gi] & ~drain)
                           | (overflow_q[gi] & ~bus.overflow_clear);
  end

  // Output stage next state: load the granted slot, else retire an accepted word.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_port_d   = out_port_q;
    last_grant_d = last_grant_q;
    if (grant_en) begin
      out_valid_d  = 1'b1;
      out_data_d   = slot_data_q[grant_idx];
      out_port_d   = grant_idx;
      last_grant_d = grant_idx;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset drops every buffered word and gives port 0 first turn.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_full_q  <= '0;
      overflow_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_port_q   <= '0;
      last_grant_q <= PORT_COUNT_WIDTH'(PORT_COUNT - 1);
      for (int i = 0; i < PORT_COUNT; i++) slot_data_q[i] <= '0;
    end else begin
      slot_full_q  <= slot_full_d;
      overflow_q   <= overflow_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_port_q   <= out_port_d;
      last_grant_q <= last_grant_d;
      for (int i = 0; i < PORT_COUNT; i++) slot_data_q[i] <= slot_data_d[i];
    end
  end

  assign bus.io_write_EF = slot_full_q;
  assign bus.overflow    = overflow_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_port    = out_port_q;

endmodule

// File: tb/tb_io_write_arbiter.sv
// Randomized and directed checks of io_write_arbiter against a cycle-level model.
module tb_io_write_arbiter;
  localparam int WW = 36;
  localparam int PC = 4;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  io_write_arbiter_if #(.WORD_WIDTH(WW), .PORT_COUNT(PC), .PORT_COUNT_WIDTH(PW)) bus ();

  io_write_arbiter #(.WORD_WIDTH(WW), .PORT_COUNT(PC), .PORT_COUNT_WIDTH(PW)) dut (
    .clock  (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  // Reference model: one-word mailbox per port, one output register, rotating pointer.
  bit              m_full [PC];
  logic [WW-1:0]   m_data [PC];
  bit [PC-1:0]     m_oflow;
  bit              m_ov;
  logic [WW-1:0]   m_od;
  int              m_op;
  int              m_last;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < PC; i++) begin
      m_full[i] = 1'b0;
      m_data[i] = '0;
    end
    m_oflow = '0;
    m_ov    = 1'b0;
    m_od    = '0;
    m_op    = 0;
    m_last  = PC - 1;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_clock();
    int g;
    int p;
    bit drain;
    bit was_full;
    g = -1;
    if (!m_ov || bus.out_ready) begin
      for (int k = 1; k <= PC; k++) begin
        p = (m_last + k) % PC;
        if (g < 0 && m_full[p]) g = p;
      end
    end
    if (g >= 0) begin
      m_ov   = 1'b1;
      m_od   = m_data[g];
      m_op   = g;
      m_last = g;
    end else if (m_ov && bus.out_ready) begin
      m_ov = 1'b0;
    end
    for (int i = 0; i < PC; i++) begin
      drain    = (g == i);
      was_full = m_full[i];
      if (bus.io_wren[i] && was_full && !drain) m_oflow[i] = 1'b1;
      else if (bus.overflow_clear)              m_oflow[i] = 1'b0;
      if (bus.io_wren[i]) begin
        if (!was_full || drain) m_data[i] = bus.io_write_data[i*WW +: WW];
        m_full[i] = 1'b1;
      end else if (drain) begin
        m_full[i] = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [PC-1:0] ef;
    for (int i = 0; i < PC; i++) ef[i] = m_full[i];
    check_eq({tag, ".ef"},    64'(bus.io_write_EF), 64'(ef));
    check_eq({tag, ".valid"}, 64'(bus.out_valid),   64'(m_ov));
    check_eq({tag, ".data"},  64'(bus.out_data),    64'(m_od));
    check_eq({tag, ".port"},  64'(bus.out_port),    64'(m_op));
    check_eq({tag, ".oflow"}, 64'(bus.overflow),    64'(m_oflow));
  endtask

  // One clock: log any transfer, advance DUT and model, compare on the falling edge.
  task automatic step(input string tag);
    if (bus.out_valid && bus.out_ready) begin
      n_xfer++;
      $display("xfer port=%0d data=%h", bus.out_port, bus.out_data);
    end
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle();
    bus.io_wren        = '0;
    bus.overflow_clear = 1'b0;
  endtask

  task automatic write_port(input int port, input logic [WW-1:0] val);
    bus.io_wren[port] = 1'b1;
    bus.io_write_data[port*WW +: WW] = val;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    rst_n              = 1'b0;
    bus.io_wren        = '0;
    bus.io_write_data  = '0;
    bus.out_ready      = 1'b1;
    bus.overflow_clear = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("por");
    rst_n = 1'b1;

    // Single write on port 2: EF next cycle, output the cycle after.
    idle(); step("t1.idle");
    write_port(2, 36'h123); step("t1.wr");
    check_eq("t1.ef_rise", 64'(bus.io_write_EF), 64'h4);
    idle(); step("t1.out");
    check_eq("t1.out_valid", 64'(bus.out_valid), 64'h1);
    check_eq("t1.out_data", 64'(bus.out_data), 64'h123);
    check_eq("t1.out_port", 64'(bus.out_port), 64'h2);
    check_eq("t1.ef_fall", 64'(bus.io_write_EF), 64'h0);

    // All four ports at once drain in port order.
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < PC; i++) write_port(i, 36'hA0 + 36'(i));
    step("t2.wr");
    idle();
    for (int k = 0; k < PC; k++) begin
      step("t2.drain");
      check_eq("t2.order", 64'(bus.out_port), 64'(k));
      check_eq("t2.data", 64'(bus.out_data), 64'hA0 + 64'(k));
    end
    check_eq("t2.nooflow", 64'(bus.overflow), 64'h0);

    // Overflow on a full, stalled slot; clear afterwards; dropped word never appears.
    do_reset();
    bus.out_ready = 1'b0;
    write_port(0, 36'hB0); step("t3.w0");
    idle(); step("t3.load");
    write_port(1, 36'hB1); step("t3.w1");
    write_port(1, 36'hB2); step("t3.w1again");
    check_eq("t3.oflow", 64'(bus.overflow), 64'h2);
    idle(); bus.overflow_clear = 1'b1; step("t3.clr");
    check_eq("t3.oflow_clr", 64'(bus.overflow), 64'h0);
    idle(); bus.out_ready = 1'b1; step("t3.release");
    check_eq("t3.kept", 64'(bus.out_data), 64'hB1);
    step("t3.drain");

    // Port 3 written every cycle: write-while-drain, full throughput.
    do_reset();
    bus.out_ready = 1'b1;
    base = n_xfer;
    for (int n = 0; n < 10; n++) begin
      write_port(3, 36'hC00 + 36'(n)); step("t4.wr");
      check_eq("t4.ef3", 64'(bus.io_write_EF[3]), 64'h1);
    end
    idle();
    for (int n = 0; n < 3; n++) step("t4.tail");
    check_eq("t4.count", 64'(n_xfer - base), 64'd10);
    check_eq("t4.nooflow", 64'(bus.overflow), 64'h0);

    // Stall with a word held: output stable, then one transfer per ready cycle.
    do_reset();
    bus.out_ready = 1'b1;
    write_port(0, 36'hD0); write_port(1, 36'hD1); step("t5.wr");
    idle(); step("t5.load");
    bus.out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      step("t5.stall");
      check_eq("t5.hold_data", 64'(bus.out_data), 64'hD0);
      check_eq("t5.hold_port", 64'(bus.out_port), 64'h0);
    end
    base = n_xfer;
    bus.out_ready = 1'b1;
    step("t5.r1"); step("t5.r2"); step("t5.r3");
    check_eq("t5.xfers", 64'(n_xfer - base), 64'd2);

    // Asynchronous reset mid-burst, then port 0 has first priority.
    do_reset();
    bus.out_ready = 1'b0;
    write_port(1, 36'hE1); write_port(2, 36'hE2); write_port(3, 36'hE3); step("t6.wr");
    idle(); step("t6.load");
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6.rst_ef", 64'(bus.io_write_EF), 64'h0);
    check_eq("t6.rst_valid", 64'(bus.out_valid), 64'h0);
    check_eq("t6.rst_data", 64'(bus.out_data), 64'h0);
    check_eq("t6.rst_port", 64'(bus.out_port), 64'h0);
    check_eq("t6.rst_oflow", 64'(bus.overflow), 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    write_port(3, 36'hF3); write_port(0, 36'hF0); step("t6.wr2");
    idle(); step("t6.first");
    check_eq("t6.prio0", 64'(bus.out_port), 64'h0);
    step("t6.second");
    check_eq("t6.then3", 64'(bus.out_port), 64'h3);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bus.io_wren = PC'($urandom_range(0, 15) & $urandom_range(0, 15));
      for (int i = 0; i < PC; i++)
        bus.io_write_data[i*WW +: WW] = {4'($urandom), 32'($urandom)};
      bus.out_ready      = ($urandom_range(0, 3) != 0);
      bus.overflow_clear = ($urandom_range(0, 15) == 0);
      step("rand");
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
